// File: rtl/exu_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and W variants.
// Operands are converted to magnitudes at accept; the sign fix-up happens on the last step.
module exu_div #(
    parameter int unsigned XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    input  logic [2:0]      i_op,
    input  logic            i_flush,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LAST_D = CW'(XLEN - 1);
    localparam logic [CW-1:0] LAST_W = CW'(31);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;
    logic [XLEN-1:0]   dvs_q;
    logic              w_q, rem_op_q, qneg_q, rneg_q, div0_q, ovf_q;
    logic              valid_q;
    logic [XLEN-1:0]   result_q;

    logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag, min_val;
    logic              a_neg, b_neg, div0, ovf;

    always_comb begin
        a_ext = i_src1;
        b_ext = i_src2;
        if (i_op[2]) begin
            a_ext = {{(XLEN-32){i_src1[31] & ~i_op[0]}}, i_src1[31:0]};
            b_ext = {{(XLEN-32){i_src2[31] & ~i_op[0]}}, i_src2[31:0]};
        end
        a_neg   = ~i_op[0] & a_ext[XLEN-1];
        b_neg   = ~i_op[0] & b_ext[XLEN-1];
        a_mag   = a_neg ? -a_ext : a_ext;
        b_mag   = b_neg ? -b_ext : b_ext;
        min_val = i_op[2] ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
        div0    = (b_ext == '0);
        ovf     = ~i_op[0] & (a_ext == min_val) & (b_ext == '1);
    end

    // One restoring step; the borrow out of the 65-bit subtraction decides the quotient bit.
    logic [XLEN:0]     shifted, diff;
    logic              fits;
    logic [XLEN-1:0]   rem_d, quo_d;

    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
        fits    = ~diff[XLEN];
        rem_d   = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
        quo_d   = {quo_q[XLEN-2:0], fits};
    end

    logic [XLEN-1:0]   q_val, r_val, sel, result_d;
    logic              last;

    always_comb begin
        if (div0_q) begin
            q_val = '1;
            r_val = quo_q;
        end else if (ovf_q) begin
            q_val = quo_q;
            r_val = '0;
        end else begin
            q_val = w_q ? {{(XLEN-32){1'b0}}, quo_d[31:0]} : quo_d;
            if (qneg_q) q_val = -q_val;
            r_val = rem_d;
            if (rneg_q) r_val = -r_val;
        end
        sel      = rem_op_q ? r_val : q_val;
        result_d = w_q ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;
        last     = div0_q | ovf_q | (cnt_q == (w_q ? LAST_W : LAST_D));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            w_q      <= 1'b0;
            rem_op_q <= 1'b0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else if (i_flush) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid) begin
                        state_q  <= S_CALC;
                        cnt_q    <= '0;
                        rem_q    <= '0;
                        dvs_q    <= b_mag;
                        w_q      <= i_op[2];
                        rem_op_q <= i_op[1];
                        qneg_q   <= a_neg ^ b_neg;
                        rneg_q   <= a_neg;
                        div0_q   <= div0;
                        ovf_q    <= ovf;
                        // Special cases keep the raw dividend; W ops left-align the magnitude.
                        if (div0 || ovf) quo_q <= a_ext;
                        else if (i_op[2]) quo_q <= a_mag << (XLEN - 32);
                        else quo_q <= a_mag;
                    end
                end
                S_CALC: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (last) begin
                        state_q  <= S_DONE;
                        cnt_q    <= '0;
                        valid_q  <= 1'b1;
                        result_q <= result_d;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        state_q <= S_IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_ready  = (state_q == S_IDLE);
    assign o_valid  = valid_q;
    assign o_result = result_q;

endmodule

// File: tb/tb_exu_div.sv
// Self-checking bench for exu_div: directed cases, randomized ops against an arithmetic model,
// backpressure, flush, async reset and back-to-back operation.
module tb_exu_div;

    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_src1;
    logic [63:0] i_src2;
    logic [2:0]  i_op;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_result;

    int total = 0;
    int bad   = 0;

    localparam logic [2:0] OP_DIV   = 3'b000;
    localparam logic [2:0] OP_DIVU  = 3'b001;
    localparam logic [2:0] OP_REM   = 3'b010;
    localparam logic [2:0] OP_REMU  = 3'b011;
    localparam logic [2:0] OP_DIVW  = 3'b100;
    localparam logic [2:0] OP_DIVUW = 3'b101;

    exu_div #(.XLEN(64)) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_src1   (i_src1),
        .i_src2   (i_src2),
        .i_op     (i_op),
        .i_flush  (i_flush),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RISC-V division semantics computed with plain arithmetic; lat is the expected accept-to-valid delay.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                                          output int lat);
        logic [63:0] x, y, q, r, res, mn;
        longint sx, sy;
        x = a;
        y = b;
        if (op[2]) begin
            x = op[0] ? {32'h0, a[31:0]} : {{32{a[31]}}, a[31:0]};
            y = op[0] ? {32'h0, b[31:0]} : {{32{b[31]}}, b[31:0]};
        end
        mn  = op[2] ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
        lat = op[2] ? 32 : 64;
        if (y == 64'h0) begin
            q = '1;
            r = x;
            lat = 1;
        end else if (!op[0] && x == mn && y == '1) begin
            q = x;
            r = 64'h0;
            lat = 1;
        end else if (op[0]) begin
            q = x / y;
            r = x % y;
        end else begin
            sx = x;
            sy = y;
            q = 64'(sx / sy);
            r = 64'(sx % sy);
        end
        res = op[1] ? r : q;
        if (op[2]) res = {{32{res[31]}}, res[31:0]};
        return res;
    endfunction

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0: return 64'h0;
            1: return '1;
            2: return 64'h8000_0000_0000_0000;
            3: return {$urandom, 32'h8000_0000};
            4: return 64'($urandom_range(0, 20));
            5: return {$urandom, $urandom_range(0, 9)};
            default: return {$urandom, $urandom};
        endcase
    endfunction

    // Issues one request, scrambles the inputs after accept, waits (bounded) for o_valid.
    task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                          output logic [63:0] res, output int lat);
        @(negedge clk);
        i_valid = 1'b1;
        i_op    = op;
        i_src1  = a;
        i_src2  = b;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        i_src1  = {$urandom, $urandom};
        i_src2  = {$urandom, $urandom};
        i_op    = 3'($urandom);
        lat = 0;
        while (!o_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = o_result;
        if (i_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        total++; if (o_result !== 64'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", o_result); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [10];
        logic [63:0] as  [10];
        logic [63:0] bs  [10];
        logic [63:0] exp [10];
        int          elat[10];
        logic [63:0] res;
        int          lat;
        ops[0] = OP_DIV;   as[0] = 64'hFFFF_FFFF_FFFF_FFF9; bs[0] = 64'd2;  exp[0] = 64'hFFFF_FFFF_FFFF_FFFD; elat[0] = 64;
        ops[1] = OP_REM;   as[1] = 64'hFFFF_FFFF_FFFF_FFF9; bs[1] = 64'd2;  exp[1] = 64'hFFFF_FFFF_FFFF_FFFF; elat[1] = 64;
        ops[2] = OP_REMU;  as[2] = 64'd100;  bs[2] = 64'd7;  exp[2] = 64'd2;  elat[2] = 64;
        ops[3] = OP_DIVU;  as[3] = 64'h1234; bs[3] = 64'd0;  exp[3] = '1;     elat[3] = 1;
        ops[4] = OP_REM;   as[4] = 64'h1234; bs[4] = 64'd0;  exp[4] = 64'h1234; elat[4] = 1;
        ops[5] = OP_DIV;   as[5] = 64'h8000_0000_0000_0000; bs[5] = '1; exp[5] = 64'h8000_0000_0000_0000; elat[5] = 1;
        ops[6] = OP_REM;   as[6] = 64'h8000_0000_0000_0000; bs[6] = '1; exp[6] = 64'h0; elat[6] = 1;
        ops[7] = OP_DIVW;  as[7] = 64'h0000_0000_8000_0000; bs[7] = 64'h0000_0000_FFFF_FFFF; exp[7] = 64'hFFFF_FFFF_8000_0000; elat[7] = 1;
        ops[8] = OP_DIVUW; as[8] = 64'hDEAD_BEEF_FFFF_FFFF; bs[8] = 64'h1234_5678_0000_0001; exp[8] = '1; elat[8] = 32;
        ops[9] = OP_DIVU;  as[9] = 64'hFFFF_FFFF_FFFF_FFFF; bs[9] = 64'd3;  exp[9] = 64'h5555_5555_5555_5555; elat[9] = 64;
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], as[i], bs[i], res, lat);
            total++; if (res !== exp[i]) begin bad++; $display("FAIL directed%0d_result got=%h exp=%h", i, res, exp[i]); end
            total++; if (lat !== elat[i]) begin bad++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, elat[i]); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  op;
        logic [63:0] a, b, res, exp;
        int          lat, elat;
        for (int i = 0; i < 40; i++) begin
            op  = 3'($urandom);
            a   = rnd64();
            b   = rnd64();
            exp = model(op, a, b, elat);
            run_op(op, a, b, res, lat);
            total++; if (res !== exp) begin bad++; $display("FAIL random%0d_result op=%0d a=%h b=%h got=%h exp=%h", i, op, a, b, res, exp); end
            total++; if (lat !== elat) begin bad++; $display("FAIL random%0d_latency got=%0d exp=%0d", i, lat, elat); end
        end
    endtask

    task automatic test_handshake();
        logic [63:0] res, exp;
        int          lat, elat;
        exp = model(OP_DIV, 64'd1000, 64'hFFFF_FFFF_FFFF_FFFD, elat);
        i_ready = 1'b0;
        run_op(OP_DIV, 64'd1000, 64'hFFFF_FFFF_FFFF_FFFD, res, lat);
        total++; if (res !== exp) begin bad++; $display("FAIL hold_result got=%h exp=%h", res, exp); end
        total++; if (o_ready !== 1'b0) begin bad++; $display("FAIL done_ready got=%b exp=0", o_ready); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (o_valid !== 1'b1 || o_result !== exp) begin
                bad++; $display("FAIL hold_stable%0d valid=%b result=%h exp_result=%h", i, o_valid, o_result, exp);
            end
        end
        @(negedge clk);
        i_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL handoff_valid got=%b exp=0", o_valid); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL handoff_ready got=%b exp=1", o_ready); end
    endtask

    task automatic test_flush();
        logic [63:0] res;
        int          lat, seen;
        @(negedge clk);
        i_valid = 1'b1; i_op = OP_DIV; i_src1 = 64'd123456789; i_src2 = 64'd3;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL flush_calc_ready got=%b exp=1", o_ready); end
        i_flush = 1'b0;
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (o_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_calc_novalid got=%0d exp=0", seen); end

        @(negedge clk);
        i_valid = 1'b1; i_flush = 1'b1; i_op = OP_DIVU; i_src1 = 64'd5; i_src2 = 64'd0;
        @(posedge clk);
        #1;
        i_valid = 1'b0; i_flush = 1'b0;
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL flush_beats_valid_ready got=%b exp=1", o_ready); end
        seen = 0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (o_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL flush_beats_valid_novalid got=%0d exp=0", seen); end

        i_ready = 1'b0;
        run_op(OP_DIVU, 64'd5, 64'd0, res, lat);
        total++; if (o_valid !== 1'b1) begin bad++; $display("FAIL flush_done_pre got=%b exp=1", o_valid); end
        @(negedge clk);
        i_flush = 1'b1;
        @(posedge clk);
        #1;
        i_flush = 1'b0;
        i_ready = 1'b1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL flush_done_valid got=%b exp=0", o_valid); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL flush_done_ready got=%b exp=1", o_ready); end
    endtask

    task automatic test_async_reset();
        logic [63:0] res;
        int          lat;
        @(negedge clk);
        i_valid = 1'b1; i_op = OP_DIVU; i_src1 = 64'hFFFF_0000_1234_5678; i_src2 = 64'd9;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (o_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", o_valid); end
        total++; if (o_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", o_ready); end
        total++; if (o_result !== 64'h0) begin bad++; $display("FAIL arst_result got=%h exp=0", o_result); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(OP_REMU, 64'd100, 64'd7, res, lat);
        total++; if (res !== 64'd2) begin bad++; $display("FAIL arst_recover got=%h exp=2", res); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res, exp;
        int          lat, elat;
        logic [63:0] a, b;
        for (int i = 0; i < 4; i++) begin
            a   = {$urandom, $urandom};
            b   = 64'($urandom_range(1, 1000));
            exp = model(OP_REMU, a, b, elat);
            run_op(OP_REMU, a, b, res, lat);
            total++; if (res !== exp) begin bad++; $display("FAIL b2b%0d_result got=%h exp=%h", i, res, exp); end
            total++;
            if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
                bad++; $display("FAIL b2b%0d_idle valid=%b ready=%b exp valid=0 ready=1", i, o_valid, o_ready);
            end
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = 1'b0;
        i_src1  = '0;
        i_src2  = '0;
        i_op    = '0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        test_reset();
        test_directed();
        test_random();
        test_handshake();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
